dual_port_read_checker: RTL and testbench

- Sits directly downstream of the true-dual-port BRAM read sequencer; consumes the two 16-bit read streams (port A, port B) during the read phase.
- Checks each beat against the known write pattern, accumulates per-port sums, counts mismatches, and reports a one-cycle done pulse plus a held pass/fail verdict.
- Used as the self-check stage in board bring-up and in simulation.

---
 rtl/dual_port_read_checker.sv | 179 +++++++++++++++++
 tb/tb_dual_port_read_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dual_port_read_checker.sv
// Self-check stage for the dual-port BRAM read sequencer: compares both read
// streams against the write pattern, sums them, and reports done/pass/overrun.
// Optional RDCHK_FIRST_ERR_EN adds capture of the first mismatching beat.
module dual_port_read_checker #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 50,
  parameter int unsigned BASE_A = 0,
  parameter int unsigned BASE_B = 50,
  parameter int unsigned SUM_W  = 24,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] douta,
  input  logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              overrun,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_a,
`ifdef RDCHK_FIRST_ERR_EN
  output logic [SUM_W-1:0]  sum_b,
  output logic [7:0]        first_err_idx,
  output logic [DATA_W-1:0] first_err_a,
  output logic [DATA_W-1:0] first_err_b,
  output logic              first_err_vld
`else
  output logic [SUM_W-1:0]  sum_b
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, CHECK, DONE_ST} state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               overrun_q, overrun_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [SUM_W-1:0]   sum_a_q, sum_a_d;
  logic [SUM_W-1:0]   sum_b_q, sum_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  exp_a_q, exp_a_d;
  logic [DATA_W-1:0]  exp_b_q, exp_b_d;
  logic               arm, mismatch;
`ifdef RDCHK_FIRST_ERR_EN
  logic [7:0]         fe_idx_q, fe_idx_d;
  logic [DATA_W-1:0]  fe_a_q, fe_a_d;
  logic [DATA_W-1:0]  fe_b_q, fe_b_d;
  logic               fe_vld_q, fe_vld_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= '0;
      sum_a_q   <= '0;
      sum_b_q   <= '0;
      cnt_q     <= '0;
      exp_a_q   <= DATA_W'(BASE_A);
      exp_b_q   <= DATA_W'(BASE_B);
`ifdef RDCHK_FIRST_ERR_EN
      fe_idx_q  <= '0;
      fe_a_q    <= '0;
      fe_b_q    <= '0;
      fe_vld_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
      sum_a_q   <= sum_a_d;
      sum_b_q   <= sum_b_d;
      cnt_q     <= cnt_d;
      exp_a_q   <= exp_a_d;
      exp_b_q   <= exp_b_d;
`ifdef RDCHK_FIRST_ERR_EN
      fe_idx_q  <= fe_idx_d;
      fe_a_q    <= fe_a_d;
      fe_b_q    <= fe_b_d;
      fe_vld_q  <= fe_vld_d;
`endif
    end
  end

  // start is honoured outside CHECK only, and always wins over a same-cycle beat
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    sum_a_d   = sum_a_q;
    sum_b_d   = sum_b_q;
    cnt_d     = cnt_q;
    exp_a_d   = exp_a_q;
    exp_b_d   = exp_b_q;
`ifdef RDCHK_FIRST_ERR_EN
    fe_idx_d  = fe_idx_q;
    fe_a_d    = fe_a_q;
    fe_b_d    = fe_b_q;
    fe_vld_d  = fe_vld_q;
`endif
    arm      = start && (state_q != CHECK);
    mismatch = (douta != exp_a_q) || (doutb != exp_b_q);

    if (arm) begin
      state_d   = CHECK;
      pass_d    = 1'b0;
      overrun_d = 1'b0;
      err_d     = '0;
      sum_a_d   = '0;
      sum_b_d   = '0;
      cnt_d     = '0;
      exp_a_d   = DATA_W'(BASE_A);
      exp_b_d   = DATA_W'(BASE_B);
`ifdef RDCHK_FIRST_ERR_EN
      fe_idx_d  = '0;
      fe_a_d    = '0;
      fe_b_d    = '0;
      fe_vld_d  = 1'b0;
`endif
    end else if (state_q == CHECK && rd_valid) begin
      sum_a_d = sum_a_q + SUM_W'(douta);
      sum_b_d = sum_b_q + SUM_W'(doutb);
      if (mismatch && (err_q != {ERR_W{1'b1}})) begin
        err_d = err_q + ERR_W'(1);
      end
`ifdef RDCHK_FIRST_ERR_EN
      if (mismatch && !fe_vld_q) begin
        fe_idx_d = 8'(cnt_q);
        fe_a_d   = douta;
        fe_b_d   = doutb;
        fe_vld_d = 1'b1;
      end
`endif
      exp_a_d = exp_a_q + DATA_W'(1);
      exp_b_d = exp_b_q + DATA_W'(1);
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DEPTH - 1)) begin
        state_d = DONE_ST;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end
    end else if (state_q == DONE_ST && rd_valid) begin
      overrun_d = 1'b1;
      pass_d    = 1'b0;
    end

    busy_d = (state_d == CHECK);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign overrun = overrun_q;
  assign err_cnt = err_q;
  assign sum_a   = sum_a_q;
  assign sum_b   = sum_b_q;
`ifdef RDCHK_FIRST_ERR_EN
  assign first_err_idx = fe_idx_q;
  assign first_err_a   = fe_a_q;
  assign first_err_b   = fe_b_q;
  assign first_err_vld = fe_vld_q;
`endif

endmodule

// File: tb/tb_dual_port_read_checker.sv
// Directed bench for dual_port_read_checker: clean, corrupt, gapped, overrun,
// restart, start-while-busy and mid-pass reset scenarios.
module tb_dual_port_read_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rd_valid;
  logic [15:0] douta;
  logic [15:0] doutb;
  logic        busy;
  logic        done;
  logic        pass;
  logic        overrun;
  logic [7:0]  err_cnt;
  logic [23:0] sum_a;
  logic [23:0] sum_b;
`ifdef RDCHK_FIRST_ERR_EN
  logic [7:0]  first_err_idx;
  logic [15:0] first_err_a;
  logic [15:0] first_err_b;
  logic        first_err_vld;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dual_port_read_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rd_valid (rd_valid),
    .douta    (douta),
    .doutb    (doutb),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .overrun  (overrun),
    .err_cnt  (err_cnt),
    .sum_a    (sum_a),
`ifdef RDCHK_FIRST_ERR_EN
    .sum_b    (sum_b),
    .first_err_idx (first_err_idx),
    .first_err_a   (first_err_a),
    .first_err_b   (first_err_b),
    .first_err_vld (first_err_vld)
`else
    .sum_b    (sum_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int a, input int b);
    rd_valid = 1'b1;
    douta    = 16'(a);
    doutb    = 16'(b);
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic run_pass(input int bad_idx);
    for (int i = 0; i < 50; i++) beat((i == bad_idx) ? 99 : i, 50 + i);
  endtask

  task automatic check_final(input string tag, input int sa, input int sb, input int err, input int p);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_sum_a"}, 32'(sum_a), 32'(sa));
    check({tag, "_sum_b"}, 32'(sum_b), 32'(sb));
    check({tag, "_err"},   32'(err_cnt), 32'(err));
    check({tag, "_pass"},  32'(pass), 32'(p));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rd_valid = 1'b0; douta = '0; doutb = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_sum_a", 32'(sum_a), 32'd0);
    check("rst_sum_b", 32'(sum_b), 32'd0);

    // clean pass
    do_start();
    check("clean_busy_armed", 32'(busy), 32'd1);
    run_pass(-1);
    check_final("clean", 1225, 3725, 0, 1);
    tick();
    check("clean_done_pulse", 32'(done), 32'd0);
    check("clean_pass_held", 32'(pass), 32'd1);

    // corrupt beat 10
    do_start();
    check("corrupt_cleared_sum", 32'(sum_a), 32'd0);
    run_pass(10);
    check_final("corrupt", 1314, 3725, 1, 0);
`ifdef RDCHK_FIRST_ERR_EN
    check("fe_vld", 32'(first_err_vld), 32'd1);
    check("fe_idx", 32'(first_err_idx), 32'd10);
    check("fe_a", 32'(first_err_a), 32'd99);
    check("fe_b", 32'(first_err_b), 32'd60);
`endif

    // gapped stream
    do_start();
    for (int i = 0; i < 50; i++) begin
      beat(i, 50 + i);
      if (i < 49) begin
        tick();
        if (i % 10 == 0) check("gap_busy", 32'(busy), 32'd1);
      end
    end
    check_final("gap", 1225, 3725, 0, 1);

    // overrun then restart
    tick();
    beat(7, 7);
    check("ovr_overrun", 32'(overrun), 32'd1);
    check("ovr_pass", 32'(pass), 32'd0);
    check("ovr_sum_a_unchanged", 32'(sum_a), 32'd1225);
    do_start();
    check("restart_overrun", 32'(overrun), 32'd0);
    check("restart_sum_a", 32'(sum_a), 32'd0);
    check("restart_sum_b", 32'(sum_b), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    run_pass(-1);
    check_final("restart", 1225, 3725, 0, 1);

    // start and rd_valid together in DONE_ST: start wins
    start = 1'b1; rd_valid = 1'b1; douta = 16'd5; doutb = 16'd5;
    tick();
    start = 1'b0; rd_valid = 1'b0;
    check("simul_overrun", 32'(overrun), 32'd0);
    check("simul_sum_a", 32'(sum_a), 32'd0);
    check("simul_busy", 32'(busy), 32'd1);
    run_pass(-1);
    check_final("simul", 1225, 3725, 0, 1);

    // start while busy is ignored
    do_start();
    for (int i = 0; i < 50; i++) begin
      if (i == 30) start = 1'b1;
      beat(i, 50 + i);
      start = 1'b0;
      if (i == 30) begin
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_sum_a", 32'(sum_a), 32'd465);
      end
    end
    check_final("busy_start", 1225, 3725, 0, 1);

    // reset mid-pass
    do_start();
    for (int i = 0; i <= 20; i++) beat(i, 50 + i);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum_a", 32'(sum_a), 32'd0);
    check("midrst_sum_b", 32'(sum_b), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    tick();
    check("midrst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_idle_done", 32'(done), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    do_start();
    run_pass(-1);
    check_final("fresh", 1225, 3725, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
